// File: rtl/interrupt_controller_mod.sv
// Interrupt controller: IF/IE registers, IME with delayed-EI counter,
// fixed-priority selection and a dispatch handshake toward the control unit.
module interrupt_controller_mod #(
   parameter int unsigned NUM_INT  = 5,
   parameter logic [15:0] VEC_BASE = 16'h0040,
   parameter logic [15:0] VEC_STEP = 16'h0008
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_INT-1:0]  irq_req,
   input  logic [15:0]         mem_addr,
   input  logic [7:0]          mem_wdata,
   input  logic                mem_we,
   output logic [7:0]          mem_rdata,
   output logic                mem_hit,
   input  logic                inst_boundary,
   input  logic                ime_set,
   input  logic                ime_clear,
   input  logic                reti,
   input  logic                int_ack,
   output logic                int_in,
   output logic                int_if_in,
   output logic [15:0]         int_vector,
   output logic                ime
);

   localparam int unsigned IDX_W   = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;
   localparam logic [0:0]  S_IDLE     = 1'b0;
   localparam logic [0:0]  S_DISPATCH = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         r_state_next;
   logic [NUM_INT-1:0] r_if;
   logic [7:0]         r_ie;
   logic               r_ime;
   logic [1:0]         r_ei_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [15:0]        r_int_vector;

   logic               w_hit_if;
   logic               w_hit_ie;
   logic [NUM_INT-1:0] w_pending;
   logic [IDX_W-1:0]   w_idx;
   logic               w_int_in;
   logic               w_take;
   logic               w_ack;
   logic [NUM_INT-1:0] w_ack_mask;
   logic [NUM_INT-1:0] w_if_next;
   logic [7:0]         w_if_rd;
   logic [15:0]        w_vec;
   logic               w_ime_next;
   logic [1:0]         w_ei_next;

   assign w_hit_if  = (mem_addr == ADDR_IF);
   assign w_hit_ie  = (mem_addr == ADDR_IE);
   assign mem_hit   = w_hit_if | w_hit_ie;
   assign w_pending = r_if & r_ie[NUM_INT-1:0];
   assign int_if_in = |w_pending;
   assign w_int_in  = (r_state == S_IDLE) & r_ime & (|w_pending);
   assign int_in    = w_int_in;
   assign w_take    = w_int_in & inst_boundary;
   assign w_ack     = (r_state == S_DISPATCH) & int_ack;
   assign w_vec     = VEC_BASE + VEC_STEP * 16'(w_idx);
   assign ime       = r_ime;
   assign int_vector = r_int_vector;

   // Lowest pending index has the highest priority
   always_comb begin
      w_idx = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (w_pending[i]) w_idx = IDX_W'(i);
      end
   end

   // A new request beats both a CPU write and an ack clear on the same bit
   always_comb begin
      w_ack_mask = '0;
      if (w_ack) w_ack_mask = NUM_INT'(1) << r_idx;
      w_if_next = ((mem_we & w_hit_if) ? mem_wdata[NUM_INT-1:0] : r_if);
      w_if_next = (w_if_next & ~w_ack_mask) | irq_req;
   end

   always_comb begin
      w_if_rd = 8'hFF;
      w_if_rd[NUM_INT-1:0] = r_if;
      mem_rdata = 8'hFF;
      if (w_hit_if)      mem_rdata = w_if_rd;
      else if (w_hit_ie) mem_rdata = r_ie;
   end

   always_comb begin
      r_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_take) r_state_next = S_DISPATCH;
         S_DISPATCH: if (int_ack) r_state_next = S_IDLE;
         default:    r_state_next = S_IDLE;
      endcase
   end

   // IME priority: dispatch entry, DI, RETI, EI; EI takes effect one instruction late
   always_comb begin
      w_ime_next = r_ime;
      w_ei_next  = r_ei_cnt;
      if (w_take || ime_clear) begin
         w_ime_next = 1'b0;
         w_ei_next  = 2'd0;
      end else if (reti) begin
         w_ime_next = 1'b1;
         w_ei_next  = 2'd0;
      end else if (ime_set && (r_state == S_IDLE) && !r_ime) begin
         w_ei_next = 2'd2;
      end else if (inst_boundary && (r_ei_cnt != 2'd0)) begin
         w_ei_next = r_ei_cnt - 2'd1;
         if (r_ei_cnt == 2'd1) w_ime_next = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_if         <= '0;
         r_ie         <= 8'h00;
         r_ime        <= 1'b0;
         r_ei_cnt     <= 2'd0;
         r_idx        <= '0;
         r_int_vector <= VEC_BASE;
      end else begin
         r_state  <= r_state_next;
         r_if     <= w_if_next;
         r_ime    <= w_ime_next;
         r_ei_cnt <= w_ei_next;
         if (mem_we && w_hit_ie) r_ie <= mem_wdata;
         if (w_take) begin
            r_idx        <= w_idx;
            r_int_vector <= w_vec;
         end
      end
   end

endmodule
